// File: rtl/mem_boot_loader_pkg.sv
// Shared types and defaults for the memory boot loader.
// Optional read-back verify is enabled by MEM_BOOT_LOADER_VERIFY_EN.
package mem_boot_loader_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_BASE_ADDR  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_VRD,
    ST_VCMP,
    ST_DONE,
    ST_ERROR
  } boot_state_t;

endpackage

// File: rtl/mem_boot_loader.sv
// Session loader streaming words into the 512x32 memory override port.
// Define MEM_BOOT_LOADER_VERIFY_EN to add read-back verify and error.
module mem_boot_loader
  import mem_boot_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BASE_ADDR  = DEF_BASE_ADDR
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  mem_overide,
  output logic [ADDR_WIDTH-1:0] overide_address,
  output logic [DATA_WIDTH-1:0] overide_data_in,
  output logic                  Mem_enable512x32,
  output logic                  Mem_Read,
  input  logic [DATA_WIDTH-1:0] Mem_to_datapath,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_run,
  output logic                  error
);

  localparam int CW = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] MAX_CNT =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  localparam logic [ADDR_WIDTH-1:0] BASE =
    ADDR_WIDTH'(BASE_ADDR);

  boot_state_t state_q;
  boot_state_t state_n;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CW-1:0]         remaining_q;
  logic                  done_q;

  logic [CW-1:0] count_c;
  logic          start_ok;
  logic          take;
  logic          last;
  logic          advance;

  assign count_c = (word_count > MAX_CNT) ?
                   MAX_CNT : word_count;

  assign start_ok = start &&
    (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});

  assign take = (state_q == ST_ACCEPT) && s_valid;
  assign last = (remaining_q == CW'(1));

`ifdef MEM_BOOT_LOADER_VERIFY_EN
  logic err_q;
  logic mismatch;

  assign mismatch = (state_q == ST_VCMP) &&
                    (Mem_to_datapath != data_q);
  assign advance  = (state_q == ST_VCMP) && !mismatch;
  assign error    = err_q;
`else
  // Read data is only consumed by the verify path.
  logic unused_rd;

  assign unused_rd = ^Mem_to_datapath;
  assign advance   = (state_q == ST_WRITE);
  assign error     = 1'b0;
`endif

  always_comb begin
    state_n          = state_q;
    s_ready          = 1'b0;
    mem_overide      = 1'b0;
    busy             = 1'b0;
    Mem_enable512x32 = 1'b0;
    Mem_Read         = 1'b0;
    cpu_run          = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start)
          state_n = (count_c == '0) ?
                    ST_DONE : ST_ACCEPT;
      end
      ST_DONE: begin
        cpu_run = 1'b1;
        if (start)
          state_n = (count_c == '0) ?
                    ST_DONE : ST_ACCEPT;
      end
      ST_ACCEPT: begin
        s_ready     = 1'b1;
        mem_overide = 1'b1;
        busy        = 1'b1;
        if (s_valid)
          state_n = ST_WRITE;
      end
      ST_WRITE: begin
        mem_overide      = 1'b1;
        busy             = 1'b1;
        Mem_enable512x32 = 1'b1;
`ifdef MEM_BOOT_LOADER_VERIFY_EN
        state_n = ST_VRD;
`else
        state_n = last ? ST_DONE : ST_ACCEPT;
`endif
      end
`ifdef MEM_BOOT_LOADER_VERIFY_EN
      ST_VRD: begin
        mem_overide      = 1'b1;
        busy             = 1'b1;
        Mem_enable512x32 = 1'b1;
        Mem_Read         = 1'b1;
        state_n          = ST_VCMP;
      end
      ST_VCMP: begin
        mem_overide = 1'b1;
        busy        = 1'b1;
        if (mismatch)
          state_n = ST_ERROR;
        else
          state_n = last ? ST_DONE : ST_ACCEPT;
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_n;
      // Pulse on entry, including a zero-count restart from DONE.
      done_q  <= (state_n == ST_DONE) &&
                 ((state_q != ST_DONE) || start);
      if (start_ok) begin
        remaining_q <= count_c;
        addr_q      <= BASE;
      end
      if (take)
        data_q <= s_data;
      if (advance) begin
        remaining_q <= remaining_q - CW'(1);
        addr_q      <= addr_q + ADDR_WIDTH'(1);
      end
    end
  end

`ifdef MEM_BOOT_LOADER_VERIFY_EN
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear)
      err_q <= 1'b0;
    else if (start_ok)
      err_q <= 1'b0;
    else if (mismatch)
      err_q <= 1'b1;
  end
`endif

  assign overide_address = addr_q;
  assign overide_data_in = data_q;
  assign done            = done_q;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench for mem_boot_loader, default and verify builds.
// Two instances: base address 0 and base address 510 (wrap case).
module tb_mem_boot_loader;

`ifdef MEM_BOOT_LOADER_VERIFY_EN
  localparam int CPW = 4;
`else
  localparam int CPW = 2;
`endif

  logic        Clock = 1'b0;
  logic        clear;
  logic        start, start_b;
  logic [9:0]  word_count, word_count_b;
  logic        s_valid;
  logic [31:0] s_data;

  logic        s_ready, mem_overide, Mem_enable512x32, Mem_Read;
  logic        busy, done, cpu_run, error;
  logic [8:0]  overide_address;
  logic [31:0] overide_data_in;

  logic        s_ready_b, mem_overide_b, Mem_enable512x32_b, Mem_Read_b;
  logic        busy_b, done_b, cpu_run_b, error_b;
  logic [8:0]  overide_address_b;
  logic [31:0] overide_data_in_b;

  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];
  logic [31:0] rd0 = '0;
  logic [31:0] rd1 = '0;
  logic        corrupt = 1'b0;

  logic [8:0]  log_a0[$], log_a1[$];
  logic [31:0] log_d0[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  mem_boot_loader #(.BASE_ADDR(0)) dut (
    .Clock(Clock), .clear(clear), .start(start),
    .word_count(word_count), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_overide(mem_overide),
    .overide_address(overide_address),
    .overide_data_in(overide_data_in),
    .Mem_enable512x32(Mem_enable512x32), .Mem_Read(Mem_Read),
    .Mem_to_datapath(rd0), .busy(busy), .done(done),
    .cpu_run(cpu_run), .error(error)
  );

  mem_boot_loader #(.BASE_ADDR(510)) dut_b (
    .Clock(Clock), .clear(clear), .start(start_b),
    .word_count(word_count_b), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_b), .mem_overide(mem_overide_b),
    .overide_address(overide_address_b),
    .overide_data_in(overide_data_in_b),
    .Mem_enable512x32(Mem_enable512x32_b), .Mem_Read(Mem_Read_b),
    .Mem_to_datapath(rd1), .busy(busy_b), .done(done_b),
    .cpu_run(cpu_run_b), .error(error_b)
  );

  // Synchronous memory models; reads return data one cycle after the strobe.
  always @(posedge Clock) begin
    if (mem_overide && Mem_enable512x32 && !Mem_Read) begin
      mem0[overide_address] <= overide_data_in;
      log_a0.push_back(overide_address);
      log_d0.push_back(overide_data_in);
    end
    if (Mem_enable512x32 && Mem_Read)
      rd0 <= mem0[overide_address] ^
             ((corrupt && overide_address == 9'd1) ? 32'h1 : 32'h0);
  end

  always @(posedge Clock) begin
    if (mem_overide_b && Mem_enable512x32_b && !Mem_Read_b) begin
      mem1[overide_address_b] <= overide_data_in_b;
      log_a1.push_back(overide_address_b);
    end
    if (Mem_enable512x32_b && Mem_Read_b)
      rd1 <= mem1[overide_address_b];
  end

  function automatic logic [31:0] word_of(input logic [31:0] seed,
                                          input int i);
    return seed ^ (32'(i) * 32'h9E3779B9);
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic run_session(input int n, input logic [31:0] seed,
                             input int budget, output int dc);
    int idx;
    idx = 0;
    dc  = -1;
    log_a0.delete();
    log_d0.delete();
    s_valid    = 1'b1;
    s_data     = word_of(seed, 0);
    word_count = 10'(n);
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      s_data = word_of(seed, idx);
      if (done) begin
        dc = c;
        break;
      end
      if (s_ready) idx++;
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b0; start = 1'b1; start_b = 1'b0;
    word_count = 10'd2; word_count_b = 10'd0;
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    #12;
    n_checks++;
    if ({s_ready, mem_overide, Mem_enable512x32, Mem_Read, busy, done,
         cpu_run, error, overide_address, overide_data_in} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got ovr=%b busy=%b addr=%h data=%h want all 0",
               mem_overide, busy, overide_address, overide_data_in);
    end
    start = 1'b0; s_valid = 1'b0;
    #1 clear = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_two_words();
    log_a0.delete(); log_d0.delete();
    start = 1'b1; word_count = 10'd2;
    s_valid = 1'b1; s_data = 32'hB980_0000;
    tick();
    start = 1'b0; word_count = 10'd0;
    n_checks++;
    if ({s_ready, mem_overide, busy, Mem_enable512x32} !== 4'b1110) begin
      n_fail++;
      $display("FAIL two_accept got rdy/ovr/busy/en=%b want 1110",
               {s_ready, mem_overide, busy, Mem_enable512x32});
    end
    tick();
    s_data = 32'hB600_0000;
    n_checks++;
    if (Mem_enable512x32 !== 1'b1 || Mem_Read !== 1'b0 ||
        s_ready !== 1'b0 || overide_address !== 9'd0 ||
        overide_data_in !== 32'hB980_0000) begin
      n_fail++;
      $display("FAIL two_write0 got en=%b rd=%b addr=%h data=%h want 1 0 000 b9800000",
               Mem_enable512x32, Mem_Read, overide_address, overide_data_in);
    end
    repeat (CPW) tick();
    n_checks++;
    if (Mem_enable512x32 !== 1'b1 || overide_address !== 9'd1 ||
        overide_data_in !== 32'hB600_0000) begin
      n_fail++;
      $display("FAIL two_write1 got en=%b addr=%h data=%h want 1 001 b6000000",
               Mem_enable512x32, overide_address, overide_data_in);
    end
    repeat (CPW - 2) tick();
    n_checks++;
    if (done !== 1'b0 || cpu_run !== 1'b0 || mem_overide !== 1'b1) begin
      n_fail++;
      $display("FAIL two_predone got done=%b run=%b ovr=%b want 0 0 1",
               done, cpu_run, mem_overide);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || cpu_run !== 1'b1 || mem_overide !== 1'b0 ||
        busy !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL two_done got done=%b run=%b ovr=%b busy=%b err=%b want 1 1 0 0 0",
               done, cpu_run, mem_overide, busy, error);
    end
    tick();
    s_valid = 1'b0;
    n_checks++;
    if (done !== 1'b0 || cpu_run !== 1'b1) begin
      n_fail++;
      $display("FAIL two_after got done=%b run=%b want 0 1", done, cpu_run);
    end
    n_checks++;
    if (log_a0.size() != 2 || mem0[0] !== 32'hB980_0000 ||
        mem0[1] !== 32'hB600_0000) begin
      n_fail++;
      $display("FAIL two_mem got n=%0d m0=%h m1=%h want 2 b9800000 b6000000",
               log_a0.size(), mem0[0], mem0[1]);
    end
  endtask

  task automatic test_zero_count();
    log_a0.delete();
    start = 1'b1; word_count = 10'd0;
    tick();
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || cpu_run !== 1'b1 || mem_overide !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done got done=%b run=%b ovr=%b want 1 1 0",
               done, cpu_run, mem_overide);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || log_a0.size() != 0) begin
      n_fail++;
      $display("FAIL zero_nowrite got done=%b writes=%0d want 0 0",
               done, log_a0.size());
    end
  endtask

  task automatic test_base_wrap();
    int idx, dc;
    logic [8:0] exp_a [4];
    exp_a = '{9'd510, 9'd511, 9'd0, 9'd1};
    idx = 0; dc = -1;
    log_a1.delete();
    start_b = 1'b1; word_count_b = 10'd4;
    s_valid = 1'b1; s_data = word_of(32'h1234_5678, 0);
    tick();
    start_b = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      s_data = word_of(32'h1234_5678, idx);
      if (done_b) begin
        dc = c;
        break;
      end
      if (s_ready_b) idx++;
      tick();
    end
    s_valid = 1'b0;
    n_checks++;
    if (dc != CPW * 4 + 1) begin
      n_fail++;
      $display("FAIL wrap_done_cycle got %0d want %0d", dc, CPW * 4 + 1);
    end
    n_checks++;
    if (log_a1.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_count got %0d want 4", log_a1.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (log_a1[i] !== exp_a[i]) begin
          n_fail++;
          $display("FAIL wrap_addr%0d got %0d want %0d",
                   i, log_a1[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    int idx, dc;
    logic pend;
    logic [31:0] expw;
    idx = 0; dc = -1; pend = 1'b0; expw = '0;
    log_a0.delete(); log_d0.delete();
    start = 1'b1; word_count = 10'd6;
    s_valid = 1'b0; s_data = '0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (pend) begin
        n_checks++;
        if (Mem_enable512x32 !== 1'b1 || Mem_Read !== 1'b0 ||
            overide_data_in !== expw) begin
          n_fail++;
          $display("FAIL gap_write got en=%b data=%h want 1 %h",
                   Mem_enable512x32, overide_data_in, expw);
        end
        pend = 1'b0;
      end
      if (done) begin
        dc = c;
        break;
      end
      n_checks++;
      if (s_ready && (Mem_enable512x32 || !mem_overide)) begin
        n_fail++;
        $display("FAIL gap_ready got rdy=1 en=%b ovr=%b want rdy 0",
                 Mem_enable512x32, mem_overide);
      end
      s_valid = 1'($urandom_range(0, 1));
      s_data  = s_valid ? word_of(32'hCAFE_0000, idx) : 32'h5555_AAAA;
      if (s_valid && s_ready) begin
        pend = 1'b1;
        expw = s_data;
        idx++;
      end
      tick();
    end
    s_valid = 1'b0;
    n_checks++;
    if (dc < 0 || log_a0.size() != 6) begin
      n_fail++;
      $display("FAIL gap_session got done_cycle=%0d writes=%0d want done 6",
               dc, log_a0.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (log_a0[i] !== 9'(i) ||
            log_d0[i] !== word_of(32'hCAFE_0000, i)) begin
          n_fail++;
          $display("FAIL gap_order%0d got %h:%h want %h:%h", i,
                   log_a0[i], log_d0[i], 9'(i), word_of(32'hCAFE_0000, i));
        end
      end
    end
  endtask

  task automatic test_clear_abort();
    int dc;
    log_a0.delete(); log_d0.delete();
    start = 1'b1; word_count = 10'd8;
    s_valid = 1'b1; s_data = 32'h0BAD_F00D;
    tick();
    start = 1'b0;
    repeat (CPW * 2 + 1) tick();
    #1 clear = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, mem_overide, Mem_enable512x32, Mem_Read, busy, done,
         cpu_run, error, overide_address, overide_data_in} !== '0) begin
      n_fail++;
      $display("FAIL clear_outputs got ovr=%b en=%b addr=%h data=%h want all 0",
               mem_overide, Mem_enable512x32, overide_address, overide_data_in);
    end
    n_checks++;
    if (log_a0.size() != 2) begin
      n_fail++;
      $display("FAIL clear_writes got %0d want 2", log_a0.size());
    end
    #2 clear = 1'b1;
    s_valid = 1'b0;
    tick();
    run_session(8, 32'h7700_0011, 200, dc);
    n_checks++;
    if (dc != CPW * 8 + 1) begin
      n_fail++;
      $display("FAIL clear_rerun_cycle got %0d want %0d", dc, CPW * 8 + 1);
    end
    n_checks++;
    if (log_a0.size() != 8 || log_a0[7] !== 9'd7 ||
        log_d0[7] !== word_of(32'h7700_0011, 7)) begin
      n_fail++;
      $display("FAIL clear_rerun_data got n=%0d want 8 words at 0..7",
               log_a0.size());
    end
  endtask

  task automatic test_clamp();
    int dc;
    run_session(1023, 32'h0F0F_0000, 2300, dc);
    n_checks++;
    if (dc != CPW * 512 + 1) begin
      n_fail++;
      $display("FAIL clamp_cycle got %0d want %0d", dc, CPW * 512 + 1);
    end
    n_checks++;
    if (log_a0.size() != 512 || log_a0[0] !== 9'd0 ||
        log_a0[511] !== 9'd511 ||
        log_d0[511] !== word_of(32'h0F0F_0000, 511)) begin
      n_fail++;
      $display("FAIL clamp_writes got n=%0d want 512 at 0..511",
               log_a0.size());
    end
  endtask

`ifdef MEM_BOOT_LOADER_VERIFY_EN
  task automatic test_verify_error();
    int dc;
    corrupt = 1'b1;
    start = 1'b1; word_count = 10'd3;
    s_valid = 1'b1; s_data = 32'h1111_2222;
    tick();
    start = 1'b0;
    repeat (7) tick();
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL verify_vcmp got err=%b busy=%b want 0 1", error, busy);
    end
    tick();
    n_checks++;
    if (error !== 1'b1 || cpu_run !== 1'b0 || mem_overide !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL verify_error got err=%b run=%b ovr=%b busy=%b done=%b want 1 0 0 0 0",
               error, cpu_run, mem_overide, busy, done);
    end
    repeat (5) tick();
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL verify_sticky got err=%b busy=%b rdy=%b want 1 0 0",
               error, busy, s_ready);
    end
    corrupt = 1'b0;
    run_session(2, 32'h4444_5555, 100, dc);
    n_checks++;
    if (dc != 9 || error !== 1'b0 || cpu_run !== 1'b1) begin
      n_fail++;
      $display("FAIL verify_recover got cycle=%0d err=%b run=%b want 9 0 1",
               dc, error, cpu_run);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_two_words();
    test_zero_count();
    test_base_wrap();
    test_gaps();
    test_clear_abort();
    test_clamp();
`ifdef MEM_BOOT_LOADER_VERIFY_EN
    test_verify_error();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_boot_loader.md
# mem_boot_loader

Session-based program loader sitting upstream of the System memory override port. It accepts a stream of 32-bit instruction/data words over a valid/ready handshake and writes them into consecutive locations of the 512x32 memory via `mem_overide`/`overide_address`/`overide_data_in`/`Mem_enable512x32`. When the session completes it releases the override and asserts `cpu_run` so the control sequencer can begin instruction fetch at PC 0.

## Interface
- `DATA_WIDTH`, 32, memory word width
- `ADDR_WIDTH`, 9, memory address width
- `BASE_ADDR`, 0, first address written in each session
- `Clock` in 1: system clock, all state on rising edge
- `clear` in 1: reset, asynchronous, active-low
- `start` in 1: one-cycle request to begin a load session; sampled only in IDLE, DONE, ERROR
- `word_count` in ADDR_WIDTH+1: words to load, sampled with `start`; values above 2^ADDR_WIDTH clamp to 2^ADDR_WIDTH
- `s_valid` in 1: upstream word valid
- `s_data` in DATA_WIDTH: upstream word
- `s_ready` out 1: loader can take a word this cycle
- `mem_overide` out 1: memory port owned by loader
- `overide_address` out ADDR_WIDTH: target address
- `overide_data_in` out DATA_WIDTH: word to write
- `Mem_enable512x32` out 1: one-cycle memory access strobe
- `Mem_Read` out 1: read select during verify (tied 0 when verify is compiled out)
- `Mem_to_datapath` in DATA_WIDTH: memory read data (unused when verify is compiled out)
- `busy` out 1: session in progress
- `done` out 1: one-cycle pulse at session end
- `cpu_run` out 1: level; CPU may run
- `error` out 1: sticky verify mismatch flag

## Operation
- States: IDLE, ACCEPT, WRITE, VRD, VCMP, DONE, ERROR.
- IDLE: all outputs 0. On `start` with clamped count 0, go to DONE. On `start` with a nonzero count, load `remaining` with the count, set address to BASE_ADDR, and go to ACCEPT.
- ACCEPT: `mem_overide`=1, `busy`=1, `s_ready`=1. When `s_valid` is high, register `s_data` into `overide_data_in` and go to WRITE.
- WRITE: `Mem_enable512x32`=1 and `Mem_Read`=0 for exactly one cycle. Without verify: decrement `remaining` and increment the address, then go to DONE if `remaining` was 1, else ACCEPT. With verify: go to VRD.
- VRD: `Mem_enable512x32`=1 and `Mem_Read`=1 for one cycle, same address. Then go to VCMP.
- VCMP: compare `Mem_to_datapath` with `overide_data_in`.
  - Mismatch: set `error` and go to ERROR.
  - Match: advance as in WRITE.
- DONE: `mem_overide`=0, `busy`=0, `cpu_run`=1. `done` pulses for the entry cycle only. A new `start` clears `cpu_run` and `error` and re-enters the session path as from IDLE.
- ERROR: `mem_overide`=0, `busy`=0, `cpu_run`=0, `error`=1. Only a new `start` or `clear` leaves this state.
- Address arithmetic is modulo 2^ADDR_WIDTH; BASE_ADDR plus a full count wraps through 0.
- `start` during ACCEPT/WRITE/VRD/VCMP is ignored.
- `s_valid` held high across sessions: at most one word is taken per ACCEPT visit.

## Timing
- Reset value of every output is 0. `clear` low mid-session aborts immediately and asynchronously: override is released, memory contents are undefined, state returns to IDLE.
- `overide_address` and `overide_data_in` are registered and stable for the whole WRITE/VRD/VCMP window.
- Throughput is 2 cycles per word without verify, 4 with verify (best case, `s_valid` always high).
- Session with N words: `start` is seen at edge 0, the last write occurs in cycle 2N, and `done`/`cpu_run` rise in cycle 2N+1 (4N+1 with verify).
- Memory read latency: data is valid on `Mem_to_datapath` in the cycle after the VRD strobe.
- `mem_overide` falls in the same cycle `cpu_run` rises.

## Configuration
- `MEM_BOOT_LOADER_VERIFY_EN` defined: the VRD/VCMP states, `Mem_Read` drive, the comparator and `error` are present.
- Undefined: WRITE advances directly, `Mem_Read` and `error` are tied 0, and `Mem_to_datapath` is ignored.

## Structure
- Shared package `mem_boot_loader_pkg`: state enum `boot_state_t`, the default DATA_WIDTH/ADDR_WIDTH constants, and the BASE_ADDR default.
- Single flat module; no sub-module warranted. The address/remaining counters and FSM sit in one always block with an async-low reset.

## Test plan
- Load 2 words (`out r3` = 0xB9800000, `in r4` = 0xB6000000), `s_valid` constant -> writes to addr 0,1; `done` pulse at cycle 5; `cpu_run`=1; `mem_overide`=0.
- `word_count`=0 -> `done` pulse the cycle after `start`; no `Mem_enable512x32` strobe.
- BASE_ADDR=510, 4 words -> addresses 510, 511, 0, 1.
- `s_valid` toggled with random gaps -> each word written exactly once and in order; `s_ready` is low outside ACCEPT.
- `clear` low during word 3 of 8 -> all outputs 0 within the cycle; a subsequent `start` with 8 words completes normally.
- Verify build, memory model corrupts addr 1 -> `error`=1, state ERROR, `cpu_run`=0; a following `start` clears `error`.
